// File: rtl/axil_pkg.sv
// ----------------------------------------------------------------------------
// axil_pkg
// Shared constants and FSM encodings for the AXI4-Lite data RAM slice.
//   ADDR_W / DATA_W / STRB_W : AXI4-Lite address, data and strobe widths
//   RESP_OKAY / RESP_SLVERR  : AXI response codes
//   w_state_e / r_state_e    : write and read channel FSM states
// ----------------------------------------------------------------------------
package axil_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_data_ram_if.sv
// ----------------------------------------------------------------------------
// axil_data_ram_if
// AXI4-Lite bundle (AW/W/B and AR/R channels) between the load/store unit
// (master) and the data RAM (slave).
//   master : drives addresses, write data/strobes, valids and bready/rready
//   slave  : drives readys, bresp/bvalid and rdata/rresp/rvalid
// ----------------------------------------------------------------------------
interface axil_data_ram_if;
    import axil_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/bram_1r1w_be.sv
// ----------------------------------------------------------------------------
// bram_1r1w_be
// Synchronous single-read / single-write RAM with per-byte write enables.
// A read and a write to the same word on one edge returns the old contents.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset of the read data register only
//   we_i    : write enable;  waddr_i / wdata_i / be_i : write port
//   re_i    : read enable;   raddr_i : read word index
//   rdata_o : registered read data
// ----------------------------------------------------------------------------
module bram_1r1w_be
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // register below is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be_i[b]) begin
                    mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignment means a same-edge read sees the value
    // before the write above lands (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/axil_data_ram.sv
// ----------------------------------------------------------------------------
// axil_data_ram
// AXI4-Lite slave data memory serving the core's load/store unit. Write and
// read channels are independent FSMs; each accepted request returns exactly
// one response. Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
// Optional feature macro: AXIL_DATA_RAM_RANGE_CHECK_EN -- out-of-range
// accesses return SLVERR (writes suppressed, reads return zero); without it
// addresses wrap modulo the RAM size and every response is OKAY.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset
//   axi   : AXI4-Lite slave modport (AW/W/B and AR/R channels)
// ----------------------------------------------------------------------------
module axil_data_ram
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic           clk_i,
    input  logic           rst_i,
    axil_data_ram_if.slave axi
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // Address decode
    logic [ADDR_W-1:0] aw_off, ar_off;
    logic              aw_oor, ar_oor;
    logic              unused_off_bits;

    assign aw_off = axi.awaddr - BASE_ADDR;
    assign ar_off = axi.araddr - BASE_ADDR;

`ifdef AXIL_DATA_RAM_RANGE_CHECK_EN
    assign aw_oor = (axi.awaddr < BASE_ADDR) || (aw_off[ADDR_W-1:IDX_W+2] != '0);
    assign ar_oor = (axi.araddr < BASE_ADDR) || (ar_off[ADDR_W-1:IDX_W+2] != '0);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Byte-offset bits (and, when wrapping, the high bits) do not select a word.
    assign unused_off_bits = ^{aw_off[1:0], ar_off[1:0],
                               aw_off[ADDR_W-1:IDX_W+2], ar_off[ADDR_W-1:IDX_W+2]};

    // Write channel
    w_state_e          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic              w_err_q, w_err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              ram_we;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        w_idx_d   = w_idx_q;
        w_err_d   = w_err_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;

        unique case (w_state_q)
            W_IDLE: begin
                if (axi.awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    w_idx_d  = aw_off[IDX_W+1:2];
                    w_err_d  = aw_oor;
                end
                if (axi.wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = axi.wdata;
                    wstrb_d = axi.wstrb;
                end
                // Both halves held: commit to RAM on this edge, respond next cycle.
                if (aw_got_q && w_got_q) begin
                    ram_we    = !w_err_q;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_err_q ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
        endcase

        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            w_idx_q   <= w_idx_d;
            w_err_q   <= w_err_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read channel
    r_state_e          r_state_q, r_state_d;
    logic              ar_got_q, ar_got_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d;
    logic              r_err_q, r_err_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        r_state_d = r_state_q;
        ar_got_d  = ar_got_q;
        r_idx_d   = r_idx_q;
        r_err_d   = r_err_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;

        unique case (r_state_q)
            R_IDLE: begin
                if (axi.arvalid && arready_q) begin
                    ar_got_d = 1'b1;
                    r_idx_d  = ar_off[IDX_W+1:2];
                    r_err_d  = ar_oor;
                end
                if (ar_got_q) begin
                    ram_re    = 1'b1;
                    rvalid_d  = 1'b1;
                    rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rready) begin
                    rvalid_d  = 1'b0;
                    ar_got_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
        endcase

        arready_d = (r_state_d == R_IDLE) && !ar_got_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            ar_got_q  <= 1'b0;
            r_idx_q   <= '0;
            r_err_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            ar_got_q  <= ar_got_d;
            r_idx_q   <= r_idx_d;
            r_err_q   <= r_err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    // Storage; a write is never issued on an edge that sees reset.
    bram_1r1w_be #(
        .DEPTH     (DEPTH_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we && !rst_i),
        .waddr_i (w_idx_q),
        .wdata_i (wdata_q),
        .be_i    (wstrb_q),
        .re_i    (ram_re),
        .raddr_i (r_idx_q),
        .rdata_o (ram_rdata)
    );

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    // An errored read returns zero regardless of what the RAM register holds.
    assign axi.rdata   = (rresp_q == RESP_SLVERR) ? '0 : ram_rdata;

endmodule

// File: tb/tb_axil_data_ram.sv
// ----------------------------------------------------------------------------
// tb_axil_data_ram
// Self-checking bench for axil_data_ram (DEPTH_WORDS=1024, BASE_ADDR=0).
// A word-array reference model tracks expected RAM contents and responses;
// AXIL_DATA_RAM_RANGE_CHECK_EN selects the out-of-range rules in the model.
// ----------------------------------------------------------------------------
module tb_axil_data_ram;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AXIL_DATA_RAM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_wr_acc = 0;
    int   last_rd_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_data_ram_if bus ();

    axil_data_ram #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .INIT_FILE   ("")
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .axi   (bus)
    );

    // Reference model: one 32-bit entry per word, addressed by byte address.
    logic [31:0] ref_mem [DEPTH];

    function automatic bit in_range(input logic [31:0] a);
        longint off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, d, input logic [3:0] s);
        int i;
        if (RANGE_CHECK && !in_range(a)) return 2'b10;
        i = word_of(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (RANGE_CHECK && !in_range(a)) return 32'h0;
        return ref_mem[word_of(a)];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] a);
        return (RANGE_CHECK && !in_range(a)) ? 2'b10 : 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: ready never seen within cycle budget", tag);
    endtask

    // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap
    task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s,
                             input int mode, input int gap, input string tag);
        logic [1:0] exp_resp;
        int n = 0;
        bus.bready = 1'b1;
        while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
        if (n >= 20) begin timeout(tag); return; end
        exp_resp = model_write(a, d, s);
        if (mode != 2) begin bus.awaddr = a; bus.awvalid = 1'b1; end
        if (mode != 1) begin bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; end
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (mode != 0) begin
            if (mode == 1) check({tag, " awready_dropped"}, bus.awready, 1'b0);
            else           check({tag, " wready_dropped"}, bus.wready, 1'b0);
            for (int i = 0; i < gap; i++) begin
                check({tag, " early_bvalid"}, bus.bvalid, 1'b0);
                tick();
            end
            if (mode == 1) begin bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; end
            else           begin bus.awaddr = a; bus.awvalid = 1'b1; end
            check({tag, " bvalid_before_second"}, bus.bvalid, 1'b0);
            tick();
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        last_wr_acc = cyc;
        check({tag, " bvalid_at_accept"}, bus.bvalid, 1'b0);
        tick();
        check({tag, " bvalid"}, bus.bvalid, 1'b1);
        check({tag, " bresp"}, bus.bresp, exp_resp);
        tick();
        check({tag, " bvalid_cleared"}, bus.bvalid, 1'b0);
        check({tag, " awready_back"}, bus.awready, 1'b1);
        check({tag, " wready_back"}, bus.wready, 1'b1);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] data, input string tag);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n = 0;
        data = 32'h0;
        while (!bus.arready && n < 20) begin tick(); n++; end
        if (n >= 20) begin timeout(tag); return; end
        exp_d = model_rdata(a);
        exp_r = model_rresp(a);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = (hold == 0);
        tick();
        bus.arvalid = 1'b0;
        last_rd_acc = cyc;
        check({tag, " rvalid_at_accept"}, bus.rvalid, 1'b0);
        check({tag, " arready_dropped"}, bus.arready, 1'b0);
        tick();
        check({tag, " rvalid"}, bus.rvalid, 1'b1);
        check({tag, " rdata"}, bus.rdata, exp_d);
        check({tag, " rresp"}, bus.rresp, exp_r);
        data = bus.rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_rvalid"}, bus.rvalid, 1'b1);
            check({tag, " hold_rdata"}, bus.rdata, exp_d);
            check({tag, " hold_arready"}, bus.arready, 1'b0);
        end
        bus.rready = 1'b1;
        tick();
        check({tag, " rvalid_cleared"}, bus.rvalid, 1'b0);
        check({tag, " arready_back"}, bus.arready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " awready"}, bus.awready, 1'b0);
        check({tag, " wready"}, bus.wready, 1'b0);
        check({tag, " arready"}, bus.arready, 1'b0);
        check({tag, " bvalid"}, bus.bvalid, 1'b0);
        check({tag, " rvalid"}, bus.rvalid, 1'b0);
        check({tag, " bresp"}, bus.bresp, 2'b00);
        check({tag, " rresp"}, bus.rresp, 2'b00);
        check({tag, " rdata"}, bus.rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] rd, a, old_d;
        logic [1:0]  exp_b;
        int          t0;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("post_reset awready", bus.awready, 1'b1);
        check("post_reset wready", bus.wready, 1'b1);
        check("post_reset arready", bus.arready, 1'b1);

        // Known contents for the word range used below
        for (int i = 0; i < 64; i++)
            axi_write(32'(i * 4), $urandom, 4'hF, 0, 0, "init");

        // Basic write / read-back
        axi_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, "wr10");
        axi_read(32'h10, 0, rd, "rd10");
        check("rd10 literal", rd, 32'hCAFE_F00D);

        // AW first, W three cycles later, partial strobes
        axi_write(32'h14, 32'h1122_3344, 4'hF, 0, 0, "wr14_base");
        axi_write(32'h14, 32'h5566_7788, 4'b0101, 1, 2, "wr14_split");
        axi_read(32'h14, 0, rd, "rd14");
        check("rd14 merged", rd, 32'h1166_3388);

        // W first, AW later; zero strobe writes nothing
        axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 2, 3, "wr18_wfirst");
        axi_write(32'h18, 32'hFFFF_FFFF, 4'b0000, 0, 0, "wr18_nostrb");
        axi_read(32'h18, 0, rd, "rd18");
        check("rd18 literal", rd, 32'h0BAD_F00D);

        // Read response held under rready back-pressure
        axi_read(32'h10, 5, rd, "rd10_hold");

        // Back-to-back throughput with bready/rready high
        axi_write(32'h40, 32'h0000_0001, 4'hF, 0, 0, "tp_w0");
        t0 = last_wr_acc;
        axi_write(32'h44, 32'h0000_0002, 4'hF, 0, 0, "tp_w1");
        check("write throughput", 32'(last_wr_acc - t0), 32'd3);
        axi_read(32'h40, 0, rd, "tp_r0");
        t0 = last_rd_acc;
        axi_read(32'h44, 0, rd, "tp_r1");
        check("read throughput", 32'(last_rd_acc - t0), 32'd3);

        // Same-cycle read and write of one word returns the old value
        axi_write(32'h20, 32'hAAAA_AAAA, 4'hF, 0, 0, "wr20_old");
        old_d = model_rdata(32'h20);
        exp_b = model_write(32'h20, 32'hBBBB_BBBB, 4'hF);
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        bus.wdata = 32'hBBBB_BBBB; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 32'h20; bus.arvalid = 1'b1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        tick();
        check("rbw rvalid", bus.rvalid, 1'b1);
        check("rbw rdata_old", bus.rdata, old_d);
        check("rbw rdata_literal", bus.rdata, 32'hAAAA_AAAA);
        check("rbw bvalid", bus.bvalid, 1'b1);
        check("rbw bresp", bus.bresp, exp_b);
        tick();
        axi_read(32'h20, 0, rd, "rd20_new");
        check("rd20_new literal", rd, 32'hBBBB_BBBB);

        // Reset while a write response is pending
        bus.awaddr = 32'h30; bus.awvalid = 1'b1;
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        exp_b = model_write(32'h30, 32'h1234_5678, 4'hF);
        check("rst_pend bvalid", bus.bvalid, 1'b1);
        tick();
        check("rst_pend bvalid_held", bus.bvalid, 1'b1);
        check("rst_pend bresp_held", bus.bresp, exp_b);
        rst = 1'b1;
        tick();
        check_all_zero("mid_reset");
        rst = 1'b0;
        bus.bready = 1'b1;
        tick();
        check("after_rst bvalid", bus.bvalid, 1'b0);
        check("after_rst awready", bus.awready, 1'b1);
        check("after_rst wready", bus.wready, 1'b1);
        check("after_rst arready", bus.arready, 1'b1);
        axi_read(32'h30, 0, rd, "rd30");
        check("rd30 intact", rd, 32'h1234_5678);

        // One word past the end: SLVERR with range checking, wraps to word 0 otherwise
        axi_write(32'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, "wr1000");
        axi_read(32'h1000, 0, rd, "rd1000");
        axi_read(32'h0000, 0, rd, "rd0000");

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'(4 * DEPTH);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), "rnd_wr");
            else
                axi_read(a, int'($urandom_range(0, 2)), rd, "rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
